// File: rtl/tristate_bus_arbiter.sv
// Registered round-robin arbiter that multiplexes N_CH requesters onto one shared
// tri-state bus, with a burst limit and all-off turnaround cycles between owners.
// Optional macro TSBUS_FIXED_PRIO_EN: lowest-index requester wins instead of rotation.
module tristate_bus_arbiter #(
    parameter int  N_CH      = 4,
    parameter int  W         = 8,
    parameter int  MAX_BURST = 4,
    parameter int  TURN_CYC  = 1,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*W-1:0] data_in,
    output logic [N_CH-1:0]   grant,
    output logic [W-1:0]      bus,
    output logic              bus_valid,
    output logic [CW-1:0]     owner
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [TW-1:0]   turn_cnt;
    logic [CW-1:0]   winner;
    logic            any_req;
    logic            others_req;
    logic            burst_end;
    logic            turn_end;
    logic [W-1:0]    bus_data;

    assign any_req    = |req;
    assign others_req = |(req & ~grant);
    assign burst_end  = (beat == BW'(MAX_BURST - 1));
    assign turn_end   = (turn_cnt == TW'(TURN_CYC - 1));

    // Winner selection; only meaningful when any_req is high.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = owner;
`ifdef TSBUS_FIXED_PRIO_EN
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) winner = CW'(i);
        end
`else
        // Scan downward so the nearest requester after the owner wins; the
        // owner itself is the last candidate (k == N_CH).
        for (int k = N_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(owner) + k) % N_CH;
            if (req[idx]) winner = CW'(idx);
        end
`endif
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= CW'(N_CH - 1);
            beat     <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= N_CH'(1) << winner;
                        owner <= winner;
                        beat  <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (!req[owner] || (burst_end && others_req)) begin
                        grant    <= '0;
                        beat     <= '0;
                        turn_cnt <= '0;
                        state    <= TURN;
                    end else if (burst_end) begin
                        beat <= '0;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                TURN: begin
                    if (turn_end) begin
                        turn_cnt <= '0;
                        if (any_req) begin
                            grant <= N_CH'(1) << winner;
                            owner <= winner;
                            beat  <= '0;
                            state <= OWN;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Per-channel buffers collapse into one enable-gated AND-OR mux; grant is
    // one-hot or zero, so the OR never merges two channels.
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) bus_data = bus_data | data_in[i*W +: W];
        end
    end

    assign bus_valid = |grant;
    assign bus       = bus_valid ? bus_data : {W{1'bz}};

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot0(grant)) else $error("grant is not one-hot");
    end
`endif

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Parametrised successor of the decoder-plus-tri-state-buffer mux.
- Multiplexes N_CH requesters onto one shared W-bit tri-state bus.
- A registered round-robin arbiter drives the per-channel buffer enables, with a burst limit and guaranteed all-off turnaround cycles between owners, so no two drivers ever overlap.
- Sits between peripheral bus masters and the shared data bus.

Parameters:
- N_CH, 4, number of requesting channels; at least 2.
- W, 8, bus and per-channel data width.
- MAX_BURST, 4, maximum consecutive OWN cycles while another channel is waiting; at least 1.
- TURN_CYC, 1, all-drivers-off cycles between owners; at least 1.
- CW, max(1,$clog2(N_CH)), derived owner-index width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_CH  per-channel request; bit i held high while channel i wants the bus.
- data_in  in  N_CH*W  channel i data on bits [i*W +: W].
- grant  out  N_CH  registered one-hot grant, or all zero; also the tri-state enable of channel i.
- bus  out  W  resolved tri-state bus; driven by data_in of the granted channel, otherwise 'z.
- bus_valid  out  1  high exactly when some grant bit is high.
- owner  out  CW  index of the current or last owner.

Behaviour:
- Reset is synchronous and active-high on clk. Reset values:
  - state=IDLE, grant=0, bus='z, bus_valid=0.
  - owner=N_CH-1, so channel 0 has first priority.
  - beat and turn counters=0.
- Reset mid-burst: grant drops at that edge and the bus floats the same cycle. No turnaround is needed after reset.
- Bus drivers: one tri-state buffer per channel, enable=grant[i]. The output is combinational from data_in of the granted channel (zero data latency).
- States:
  - IDLE, no grant:
    - If any req is high, the winner is registered into grant/owner at the next edge and the state goes to OWN.
    - Otherwise stay in IDLE.
  - OWN, grant[owner]=1, beat counts OWN cycles starting at 0:
    - Leave to TURN at the next edge if req[owner] is sampled low.
    - Also leave to TURN if beat==MAX_BURST-1 and any other req is high.
    - If beat reaches MAX_BURST-1 with no other requester, beat resets to 0 and ownership continues.
    - On leaving, grant=0 at that edge.
  - TURN, grant=0, bus='z for exactly TURN_CYC cycles:
    - On the last TURN cycle, if any req is high, the winner is granted at the next edge and the state goes to OWN.
    - Otherwise go to IDLE.
- Winner selection (round-robin): the first asserted req scanning from (owner+1) mod N_CH upward with wrap-around. The previous owner is eligible only if no other channel requests.
- Grant latency:
  - Request into IDLE: grant 1 cycle after req is sampled.
  - Owner change: the old grant drops, then TURN_CYC idle cycles, then the new grant. Minimum gap is TURN_CYC cycles.
- Simultaneous events:
  - If the owner drops req in the same cycle beat hits the limit, the state goes to TURN; the effect is identical.
  - A requester that drops req during TURN is not granted; arbitration samples req on the deciding edge only.
- Invariant: popcount(grant)<=1 at all times. A one-hot check is required in simulation, guarded by translate_off.

Optional Feature:
- Macro TSBUS_FIXED_PRIO_EN.
- Defined: winner = lowest-index asserted req. Rotation is ignored, but MAX_BURST preemption and TURN_CYC still apply.
- Undefined: round-robin as above.

Test Plan:
Run with N_CH=4, W=8, MAX_BURST=4, TURN_CYC=1 unless stated otherwise.
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0, bus=8'hzz, bus_valid=0, owner=3. The first cycle after release has grant=0; grant=4'b0001 one edge later.
2. Single requester: req=4'b0100, data_in ch2=8'hA5 -> grant=4'b0100 after 1 cycle, bus=8'hA5 for every cycle req stays high. req drop -> grant=0 next edge, then IDLE.
3. Burst/round-robin: req=4'b1111 held, data ch0..3=11,22,33,44 -> bus sequence 11 x4, z x1, 22 x4, z x1, 33 x4, z x1, 44 x4, z x1, then 11 again.
4. Turnaround: ch1 owns, drops req while ch3 is requesting -> exactly one cycle grant=0/bus=z, then grant=4'b1000. Repeat with TURN_CYC=3 -> three z cycles.
5. Reset mid-burst: ch0 owns with beat=2, rst pulsed -> grant=0 on the next edge. After release with req=4'b0011 -> grant=4'b0001 (owner reset to 3).
6. TSBUS_FIXED_PRIO_EN defined, req=4'b1010 held -> ch1 holds for 4 cycles, one z cycle, then ch1 again. Never ch3 while ch1 requests; ch3 granted only after req[1]=0.
